// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_sub.sv
// One-bit full subtractor: D = A - B - Bi, built from two half-subtract stages.
module full_sub (
    input  logic A,
    input  logic B,
    input  logic Bi,
    output logic D,
    output logic Bo
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    // First half-subtract: A - B
    assign w_d1 = A ^ B;
    assign w_b1 = ~A & B;

    // Second half-subtract: (A - B) - Bi, borrows merged with OR
    assign D    = w_d1 ^ Bi;
    assign w_b2 = ~w_d1 & Bi;
    assign Bo   = w_b1 | w_b2;

endmodule : full_sub

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor: one bit pair per cycle LSB-first, result
// published in a separate output register on completion.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         BI,
    output logic [W-1:0] D,
    output logic         BO,
    output logic         BUSY,
    output logic         DONE
);

    localparam int unsigned CW = $clog2(W) + 1;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_res;
    logic           r_br;
    logic [W-1:0]   r_d;
    logic           r_bo;
    logic           r_busy;
    logic           r_done;

    logic           w_d;
    logic           w_bo;
    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_res_next;

    // Per-bit cell operating on the current LSBs and the running borrow
    full_sub u_cell (
        .A  (r_a[0]),
        .B  (r_b[0]),
        .Bi (r_br),
        .D  (w_d),
        .Bo (w_bo)
    );

    // New requests are only taken when no subtraction is in flight
    assign w_accept   = START && (r_state != RUN);
    assign w_last     = (r_cnt == CW'(W - 1));
    assign w_res_next = (r_res >> 1) | {w_d, {(W-1){1'b0}}};

    // Sequencer, datapath shift registers and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_br    <= BI;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_bo;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_d     <= w_res_next;
                        r_bo    <= w_bo;
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign D    = r_d;
    assign BO   = r_bo;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: stimulus pushes expected results, a
// negedge monitor pops and checks them whenever DONE is seen.
module tb_serial_sub;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           done_cyc;
    } exp_t;

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BI;
    logic [W-1:0] D;
    logic         BO;
    logic         BUSY;
    logic         DONE;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];

    serial_sub #(.W(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .BI    (BI),
        .D     (D),
        .BO    (BO),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (DONE) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(DONE), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("d",           32'(D),    32'(e.d));
                chk("bo",          32'(BO),   32'(e.bo));
                chk("done_cycle",  32'(cyc),  32'(e.done_cyc));
                chk("busy_in_fin", 32'(BUSY), 32'(0));
            end
        end
    end

    // Issue one op from IDLE/FIN; returns the index of the accepting edge
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input logic [W-1:0] ed, input logic ebo, output int acc);
        exp_t e;
        @(negedge CLK);
        START = 1'b1; A = a; B = b; BI = bi;
        @(posedge CLK);
        #1;
        acc = cyc;
        e.d = ed; e.bo = ebo; e.done_cyc = acc + int'(W);
        q.push_back(e);
        START = 1'b0;
    endtask

    initial begin
        int acc;
        int acc2;
        int busy_cnt;
        int guard;
        logic [W:0] ref_v;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rbi;
        exp_t e;

        RST_N = 1'b1; START = 1'b0; A = '0; B = '0; BI = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        chk("rst_d",    32'(D),    32'(0));
        chk("rst_bo",   32'(BO),   32'(0));
        chk("rst_busy", 32'(BUSY), 32'(0));
        chk("rst_done", 32'(DONE), 32'(0));
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Basic vectors, second and third accepted straight from FIN
        do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, acc);
        repeat (W) @(posedge CLK);
        do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, acc);
        repeat (W) @(posedge CLK);
        do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, acc);
        repeat (W + 3) @(posedge CLK);

        // START during RUN is ignored; BUSY lasts exactly W cycles
        do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, acc);
        busy_cnt = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            START = (i == 2);
            if (i == 2) begin A = 8'hFF; B = 8'h01; BI = 1'b0; end
            busy_cnt += int'(BUSY);
        end
        chk("busy_cycles", 32'(busy_cnt - 1), 32'(W));
        START = 1'b0;
        repeat (3) @(posedge CLK);

        // Back-to-back: START held through FIN
        @(negedge CLK);
        START = 1'b1; A = 8'h20; B = 8'h10; BI = 1'b0;
        @(posedge CLK);
        #1;
        acc = cyc;
        e.d = 8'h10; e.bo = 1'b0; e.done_cyc = acc + int'(W);
        q.push_back(e);
        A = 8'h40; B = 8'h41; BI = 1'b1;
        repeat (W + 1) @(posedge CLK);
        #1;
        acc2 = cyc;
        e.d = 8'hFE; e.bo = 1'b1; e.done_cyc = acc2 + int'(W);
        q.push_back(e);
        START = 1'b0;
        chk("b2b_busy_after_fin", 32'(BUSY), 32'(1));
        repeat (W + 3) @(posedge CLK);

        // Reset in the middle of RUN aborts the op
        do_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, acc);
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        void'(q.pop_back());
        #1;
        chk("midrst_d",    32'(D),    32'(0));
        chk("midrst_bo",   32'(BO),   32'(0));
        chk("midrst_busy", 32'(BUSY), 32'(0));
        chk("midrst_done", 32'(DONE), 32'(0));
        repeat (3) @(negedge CLK);
        RST_N = 1'b1; START = 1'b1; A = 8'h80; B = 8'h01; BI = 1'b0;
        @(posedge CLK);
        #1;
        acc = cyc;
        e.d = 8'h7F; e.bo = 1'b0; e.done_cyc = acc + int'(W);
        q.push_back(e);
        START = 1'b0;
        repeat (W) @(posedge CLK);

        // Random ops checked against a W+1-bit reference subtraction
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbi = 1'($urandom);
            ref_v = {1'b0, ra} - {1'b0, rb} - (W+1)'(rbi);
            do_op(ra, rb, rbi, ref_v[W-1:0], ref_v[W], acc);
            repeat (W) @(posedge CLK);
        end

        // Drain outstanding expectations with a bounded wait
        guard = 0;
        while (q.size() != 0 && guard < 40) begin
            @(posedge CLK);
            guard++;
        end
        repeat (2) @(posedge CLK);
        chk("drain_pending", 32'(q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_sub
